// File: rtl/sop_mac_seq.sv
// sop_mac_seq: time-multiplexed sum-of-products engine.
// Captures N_PAIRS unsigned operand pairs and adds one term per cycle through a single
// W x W multiplier (or a W-bit adder when mode=1). The total is presented on a
// valid/ready output port and held there until it is taken.
module sop_mac_seq #(
   parameter  int W       = 9,
   parameter  int N_PAIRS = 6,
   localparam int ACC_W   = 2*W + $clog2(N_PAIRS)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mode,
   input  logic [N_PAIRS*W-1:0] a_bus,
   input  logic [N_PAIRS*W-1:0] b_bus,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_W-1:0]     out_data,
   output logic                 busy
);

   localparam int IDX_W = $clog2(N_PAIRS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PAIRS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                      state;
   logic [N_PAIRS-1:0][W-1:0]   a_q;
   logic [N_PAIRS-1:0][W-1:0]   b_q;
   logic                        mode_q;
   logic [IDX_W-1:0]            idx;
   logic [ACC_W-1:0]            acc;

   logic [W-1:0]                a_sel;
   logic [W-1:0]                b_sel;
   logic [2*W-1:0]              prod;
   logic [W:0]                  sum;
   logic [ACC_W-1:0]            term;
   logic [ACC_W-1:0]            acc_next;

   // Select the current pair and form its term; the operands are zero-extended so the
   // full product and the carry of the sum are kept before widening to ACC_W.
   always_comb begin
      a_sel    = a_q[idx];
      b_sel    = b_q[idx];
      prod     = {{W{1'b0}}, a_sel} * {{W{1'b0}}, b_sel};
      sum      = {1'b0, a_sel} + {1'b0, b_sel};
      term     = mode_q ? ACC_W'(sum) : ACC_W'(prod);
      acc_next = acc + term;
   end

   // Control FSM with registered handshake outputs; out_data is loaded only on the
   // final accumulation so it keeps the last result after the block returns to IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         mode_q    <= 1'b0;
         idx       <= '0;
         acc       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q      <= a_bus;
                  b_q      <= b_bus;
                  mode_q   <= mode;
                  acc      <= '0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               acc <= acc_next;
               if (idx == IDX_LAST) begin
                  out_data  <= acc_next;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            S_DONE: begin
               // A bundle offered at the same edge waits for the next IDLE cycle.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sop_mac_seq.sv
// tb_sop_mac_seq: randomized self-checking bench for sop_mac_seq. Expected results come
// from a plain-arithmetic model of the sum of products / sums over the captured bundle.
module tb_sop_mac_seq;

   localparam int W       = 9;
   localparam int N_PAIRS = 6;
   localparam int ACC_W   = 2*W + $clog2(N_PAIRS);
   localparam int BUS_W   = N_PAIRS*W;

   logic             clock;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic             mode;
   logic [BUS_W-1:0] a_bus;
   logic [BUS_W-1:0] b_bus;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic             busy;

   int errs   = 0;
   int checks = 0;

   sop_mac_seq #(.W(W), .N_PAIRS(N_PAIRS)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .a_bus     (a_bus),
      .b_bus     (b_bus),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [BUS_W-1:0] rand_bus();
      logic [BUS_W-1:0] v;
      for (int k = 0; k < N_PAIRS; k++) v[k*W +: W] = W'($urandom);
      return v;
   endfunction

   // Reference: sum over pairs of a*b (mode 0) or a+b (mode 1), unbounded integers.
   function automatic longint model(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b,
                                    input logic m);
      longint s;
      longint x;
      longint y;
      s = 0;
      for (int k = 0; k < N_PAIRS; k++) begin
         x = longint'(a[k*W +: W]);
         y = longint'(b[k*W +: W]);
         s += m ? (x + y) : (x * y);
      end
      return s;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Offer a bundle and let it be accepted; leaves the bench 1 time unit after that edge.
   task automatic accept(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b,
                         input logic m, input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, longint'(in_ready), 1);
      a_bus    = a;
      b_bus    = b;
      mode     = m;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({tag, "_busy"}, longint'(busy), 1);
   endtask

   // Count edges from the accept until out_valid and compare the result.
   task automatic wait_result(input bit toggle, input longint exp, input string tag);
      int lat;
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (toggle) begin
            a_bus = rand_bus();
            b_bus = rand_bus();
            mode  = ~mode;
         end
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, N_PAIRS);
      chk({tag, "_data"}, longint'(out_data), exp);
   endtask

   task automatic take(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_ovld_clr"}, longint'(out_valid), 0);
      chk({tag, "_irdy_set"}, longint'(in_ready), 1);
   endtask

   initial begin
      logic [BUS_W-1:0] a;
      logic [BUS_W-1:0] b;
      logic [BUS_W-1:0] ya;
      logic [BUS_W-1:0] yb;
      logic             m;
      longint           exp;

      reset     = 1'b1;
      in_valid  = 1'b0;
      mode      = 1'b0;
      a_bus     = '0;
      b_bus     = '0;
      out_ready = 1'b0;

      // Reset values while reset is held.
      #12;
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_out_data", longint'(out_data), 0);
      @(negedge clock);
      reset = 1'b0;
      tick();

      // Maximum operands, mode 0.
      for (int k = 0; k < N_PAIRS; k++) begin
         a[k*W +: W] = W'(511);
         b[k*W +: W] = W'(511);
      end
      accept(a, b, 1'b0, "max");
      wait_result(1'b0, 1566726, "max");
      take("max");

      // Pairs (1,2)..(11,12) in both modes.
      for (int k = 0; k < N_PAIRS; k++) begin
         a[k*W +: W] = W'(2*k + 1);
         b[k*W +: W] = W'(2*k + 2);
      end
      accept(a, b, 1'b1, "seq_m1");
      wait_result(1'b0, 78, "seq_m1");
      take("seq_m1");
      accept(a, b, 1'b0, "seq_m0");
      wait_result(1'b0, 322, "seq_m0");
      take("seq_m0");

      // Backpressure: result held while a new bundle is offered and ignored.
      a   = rand_bus();
      b   = rand_bus();
      m   = 1'($urandom);
      exp = model(a, b, m);
      accept(a, b, m, "bp");
      wait_result(1'b0, exp, "bp");
      ya       = rand_bus();
      yb       = rand_bus();
      a_bus    = ya;
      b_bus    = yb;
      mode     = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold_data", longint'(out_data), exp);
         chk("bp_hold_vld", longint'(out_valid), 1);
         chk("bp_hold_irdy", longint'(in_ready), 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_rel_vld", longint'(out_valid), 0);
      chk("bp_rel_irdy", longint'(in_ready), 1);
      chk("bp_rel_data_kept", longint'(out_data), exp);
      // in_valid is still high: the waiting bundle is taken in this IDLE cycle.
      tick();
      in_valid = 1'b0;
      chk("bp_next_busy", longint'(busy), 1);
      wait_result(1'b0, model(ya, yb, 1'b0), "bp_next");
      take("bp_next");

      // Operand buses and mode changing every cycle while running.
      a   = rand_bus();
      b   = rand_bus();
      m   = 1'($urandom);
      exp = model(a, b, m);
      accept(a, b, m, "toggle");
      wait_result(1'b1, exp, "toggle");
      take("toggle");

      // Random transactions with random downstream delay.
      for (int t = 0; t < 8; t++) begin
         a   = rand_bus();
         b   = rand_bus();
         m   = 1'($urandom);
         exp = model(a, b, m);
         accept(a, b, m, "rnd");
         wait_result(1'b0, exp, "rnd");
         for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
         chk("rnd_hold", longint'(out_data), exp);
         take("rnd");
      end

      // Reset mid-run at idx=3, asserted between edges.
      accept(rand_bus(), rand_bus(), 1'b0, "mid");
      tick();
      tick();
      tick();
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_irdy", longint'(in_ready), 1);
      chk("mid_rst_ovld", longint'(out_valid), 0);
      chk("mid_rst_busy", longint'(busy), 0);
      chk("mid_rst_data", longint'(out_data), 0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("mid_no_ovld", longint'(out_valid), 0);
      end
      for (int k = 0; k < N_PAIRS; k++) begin
         a[k*W +: W] = W'(1);
         b[k*W +: W] = W'(1);
      end
      accept(a, b, 1'b0, "ones");
      wait_result(1'b0, 6, "ones");
      take("ones");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
